// File: rtl/regfile_writeback_pkg.sv
// Shared core package: register index width helper and the writeback source
// encoding used by the writeback stage and the register file bench.
package regfile_writeback_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LD   = 2'd2
    } wb_src_e;

    // Width of a register index for a file of num_regs entries (at least 1 bit)
    function automatic int rw_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_writeback_ld_scoreboard.sv
// Outstanding-load tracker: one pending bit per register plus a count of loads
// in flight. It decides whether a new load may issue and answers pending
// lookups for the hazard logic in the writeback stage.
module ld_scoreboard
    import regfile_writeback_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter bit R0_IS_ZERO = 1'b1,
    parameter int MAX_LD     = 4,
    parameter int RW         = rw_width(NUM_REGS)
) (
    input  logic          Clk_i,
    input  logic          Rst_ni,
    input  logic          issue,
    input  logic [RW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic          rsp_consumed,
    input  logic [RW-1:0] rsp_rd,
    input  logic [RW-1:0] ra_sel,
    input  logic [RW-1:0] rb_sel,
    input  logic [RW-1:0] alu_rd,
    output logic          ra_pend,
    output logic          rb_pend,
    output logic          alu_pend
);

    localparam int CW = $clog2(MAX_LD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LD);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [CW-1:0]       ld_cnt;
    logic                issue_accept;
    logic                issue_to_zero;

    // A retiring response frees a slot in the same cycle, so a full tracker can
    // still accept; a load to an already-pending register must wait so a set and
    // a clear of the same bit never land together.
    assign issue_ready   = ((ld_cnt < MAX_CNT) || rsp_consumed) && !pend[issue_rd];
    assign issue_accept  = issue && issue_ready;
    assign issue_to_zero = R0_IS_ZERO && (issue_rd == '0);

    assign ra_pend  = pend[ra_sel];
    assign rb_pend  = pend[rb_sel];
    assign alu_pend = pend[alu_rd];

    // Next pending vector: clear on retiring response, set on accepted issue
    always_comb begin
        pend_next = pend;
        if (rsp_consumed) begin
            pend_next[rsp_rd] = 1'b0;
        end
        if (issue_accept && !issue_to_zero) begin
            pend_next[issue_rd] = 1'b1;
        end
    end

    // Pending bits; reset discards every outstanding load
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Loads in flight; an unexpected response cannot drive the count below zero
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            ld_cnt <= '0;
        end else if (issue_accept && !rsp_consumed) begin
            ld_cnt <= ld_cnt + CW'(1);
        end else if (!issue_accept && rsp_consumed && (ld_cnt != '0)) begin
            ld_cnt <= ld_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage owning the register file write port. ALU results win over
// load responses; the chosen write is registered, and its value is forwarded
// to the read ports during the cycle before the register file commits it.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter bit R0_IS_ZERO = 1'b1,
    parameter int MAX_LD     = 4,
    parameter int RW         = rw_width(NUM_REGS)
) (
    input  logic                 Clk_i,
    input  logic                 Rst_ni,
    input  logic                 Alu_We_i,
    input  logic [RW-1:0]        Alu_Rd_i,
    input  logic [REG_WIDTH-1:0] Alu_Data_i,
    input  logic                 Ld_Issue_i,
    input  logic [RW-1:0]        Ld_Issue_Rd_i,
    output logic                 Ld_Issue_Ready_o,
    input  logic                 Ld_Valid_i,
    input  logic [RW-1:0]        Ld_Rd_i,
    input  logic [REG_WIDTH-1:0] Ld_Data_i,
    output logic                 Ld_Ready_o,
    input  logic [RW-1:0]        Ra_Sel_i,
    input  logic [RW-1:0]        Rb_Sel_i,
    input  logic                 Ra_Use_i,
    input  logic                 Rb_Use_i,
    input  logic [REG_WIDTH-1:0] Ra_Rf_i,
    input  logic [REG_WIDTH-1:0] Rb_Rf_i,
    output logic [REG_WIDTH-1:0] Ra_o,
    output logic [REG_WIDTH-1:0] Rb_o,
    output logic                 Stall_o,
    output logic                 Wb_We_o,
    output logic [RW-1:0]        Wb_Rd_o,
    output logic [REG_WIDTH-1:0] Wb_Data_o
);

    wb_src_e wb_src;
    logic    ld_consumed;
    logic    alu_rd_zero;
    logic    ld_rd_zero;
    logic    ra_pend;
    logic    rb_pend;
    logic    alu_pend;

    assign Ld_Ready_o  = !Alu_We_i;
    assign ld_consumed = Ld_Valid_i && !Alu_We_i;
    assign alu_rd_zero = R0_IS_ZERO && (Alu_Rd_i == '0);
    assign ld_rd_zero  = R0_IS_ZERO && (Ld_Rd_i == '0);

    ld_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .R0_IS_ZERO (R0_IS_ZERO),
        .MAX_LD     (MAX_LD),
        .RW         (RW)
    ) u_ld_scoreboard (
        .Clk_i        (Clk_i),
        .Rst_ni       (Rst_ni),
        .issue        (Ld_Issue_i),
        .issue_rd     (Ld_Issue_Rd_i),
        .issue_ready  (Ld_Issue_Ready_o),
        .rsp_consumed (ld_consumed),
        .rsp_rd       (Ld_Rd_i),
        .ra_sel       (Ra_Sel_i),
        .rb_sel       (Rb_Sel_i),
        .alu_rd       (Alu_Rd_i),
        .ra_pend      (ra_pend),
        .rb_pend      (rb_pend),
        .alu_pend     (alu_pend)
    );

    // Pick this cycle's write source, ALU first
    always_comb begin
        wb_src = WB_NONE;
        if (Alu_We_i) begin
            wb_src = WB_ALU;
        end else if (ld_consumed) begin
            wb_src = WB_LD;
        end
    end

    // Registered write port; writes to a hard-wired zero register keep the
    // select and data but never assert the enable
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            Wb_We_o   <= 1'b0;
            Wb_Rd_o   <= '0;
            Wb_Data_o <= '0;
        end else begin
            case (wb_src)
                WB_ALU: begin
                    Wb_We_o   <= !alu_rd_zero;
                    Wb_Rd_o   <= Alu_Rd_i;
                    Wb_Data_o <= Alu_Data_i;
                end
                WB_LD: begin
                    Wb_We_o   <= !ld_rd_zero;
                    Wb_Rd_o   <= Ld_Rd_i;
                    Wb_Data_o <= Ld_Data_i;
                end
                default: begin
                    Wb_We_o <= 1'b0;
                end
            endcase
        end
    end

    // Hold decode on a RAW hazard against a pending load, or when an ALU write
    // would overtake a pending load to the same register
    assign Stall_o = (Ra_Use_i && ra_pend) || (Rb_Use_i && rb_pend) || (Alu_We_i && alu_pend);

    // Bypass the in-flight write until the register file has committed it
    assign Ra_o = (Wb_We_o && (Wb_Rd_o == Ra_Sel_i)) ? Wb_Data_o : Ra_Rf_i;
    assign Rb_o = (Wb_We_o && (Wb_Rd_o == Rb_Sel_i)) ? Wb_Data_o : Rb_Rf_i;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback. Register writes expected from each
// stimulus cycle are queued; a negedge monitor pops and compares every write
// the DUT presents. Combinational outputs are checked inline.
module tb_regfile_writeback;

    localparam int W  = 32;
    localparam int RW = 5;

    typedef struct {
        logic [RW-1:0] rd;
        logic [W-1:0]  data;
    } wbExp_t;

    logic          Clk_i;
    logic          Rst_ni;
    logic          aluWe;
    logic [RW-1:0] aluRd;
    logic [W-1:0]  aluData;
    logic          ldIssue;
    logic [RW-1:0] ldIssueRd;
    logic          ldIssueReady;
    logic          ldValid;
    logic [RW-1:0] ldRd;
    logic [W-1:0]  ldData;
    logic          ldReady;
    logic [RW-1:0] raSel;
    logic [RW-1:0] rbSel;
    logic          raUse;
    logic          rbUse;
    logic [W-1:0]  raRf;
    logic [W-1:0]  rbRf;
    logic [W-1:0]  raOut;
    logic [W-1:0]  rbOut;
    logic          stall;
    logic          wbWe;
    logic [RW-1:0] wbRd;
    logic [W-1:0]  wbData;

    wbExp_t expQ[$];
    int     testsRun;
    int     testsFailed;

    regfile_writeback #(
        .REG_WIDTH  (W),
        .NUM_REGS   (32),
        .R0_IS_ZERO (1'b1),
        .MAX_LD     (4)
    ) dut (
        .Clk_i            (Clk_i),
        .Rst_ni           (Rst_ni),
        .Alu_We_i         (aluWe),
        .Alu_Rd_i         (aluRd),
        .Alu_Data_i       (aluData),
        .Ld_Issue_i       (ldIssue),
        .Ld_Issue_Rd_i    (ldIssueRd),
        .Ld_Issue_Ready_o (ldIssueReady),
        .Ld_Valid_i       (ldValid),
        .Ld_Rd_i          (ldRd),
        .Ld_Data_i        (ldData),
        .Ld_Ready_o       (ldReady),
        .Ra_Sel_i         (raSel),
        .Rb_Sel_i         (rbSel),
        .Ra_Use_i         (raUse),
        .Rb_Use_i         (rbUse),
        .Ra_Rf_i          (raRf),
        .Rb_Rf_i          (rbRf),
        .Ra_o             (raOut),
        .Rb_o             (rbOut),
        .Stall_o          (stall),
        .Wb_We_o          (wbWe),
        .Wb_Rd_o          (wbRd),
        .Wb_Data_o        (wbData)
    );

    // 10 ns clock
    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    // Compare one value and keep the tallies
    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Queue the write this cycle's inputs should produce, clock it in, then
    // drop the one-shot write/issue/response inputs
    task automatic applyStimulus();
        wbExp_t e;
        if (aluWe) begin
            if (aluRd != '0) begin
                e.rd = aluRd; e.data = aluData; expQ.push_back(e);
            end
        end else if (ldValid) begin
            if (ldRd != '0) begin
                e.rd = ldRd; e.data = ldData; expQ.push_back(e);
            end
        end
        @(posedge Clk_i);
        #1;
        aluWe = 1'b0; aluRd = '0; aluData = '0;
        ldIssue = 1'b0; ldIssueRd = '0;
        ldValid = 1'b0; ldRd = '0; ldData = '0;
    endtask

    // Monitor: every enabled write must match the oldest queued expectation
    always @(negedge Clk_i) begin
        if (Rst_ni && wbWe) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL wb_unexpected: got write x%0d=0x%08h, expected no write", wbRd, wbData);
            end else begin
                wbExp_t e;
                e = expQ.pop_front();
                if (wbRd !== e.rd || wbData !== e.data) begin
                    testsFailed++;
                    $display("[TB] FAIL wb_write: got x%0d=0x%08h, expected x%0d=0x%08h",
                             wbRd, wbData, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        testsRun = 0; testsFailed = 0;
        Rst_ni = 1'b0;
        aluWe = 1'b0; aluRd = '0; aluData = '0;
        ldIssue = 1'b0; ldIssueRd = '0;
        ldValid = 1'b0; ldRd = '0; ldData = '0;
        raSel = '0; rbSel = '0; raUse = 1'b0; rbUse = 1'b0; raRf = '0; rbRf = '0;

        // Reset state
        #1;
        checkOutput("rst_wb_we", W'(wbWe), 0);
        checkOutput("rst_wb_rd", W'(wbRd), 0);
        checkOutput("rst_wb_data", wbData, 0);
        checkOutput("rst_issue_ready", W'(ldIssueReady), 1);
        checkOutput("rst_stall", W'(stall), 0);
        checkOutput("rst_ld_ready", W'(ldReady), 1);
        @(posedge Clk_i); #1;
        @(posedge Clk_i); #1;
        Rst_ni = 1'b1;

        // ALU write x5 and forward it on the following cycle
        aluWe = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
        applyStimulus();
        raSel = 5'd5; raUse = 1'b1; raRf = '0;
        rbSel = 5'd5; rbUse = 1'b1; rbRf = '0;
        #1;
        checkOutput("fwd_ra_x5", raOut, 32'hDEADBEEF);
        checkOutput("fwd_rb_x5", rbOut, 32'hDEADBEEF);
        checkOutput("fwd_no_stall", W'(stall), 0);
        rbUse = 1'b0; rbSel = '0;

        // Load to x7: RAW stall until one cycle after the response retires
        ldIssue = 1'b1; ldIssueRd = 5'd7;
        #1;
        checkOutput("ld7_issue_ready", W'(ldIssueReady), 1);
        applyStimulus();
        raSel = 5'd7; ldIssueRd = 5'd7;
        #1;
        checkOutput("ld7_raw_stall", W'(stall), 1);
        checkOutput("ld7_reissue_blocked", W'(ldIssueReady), 0);
        applyStimulus();
        ldValid = 1'b1; ldRd = 5'd7; ldData = 32'h1234;
        #1;
        checkOutput("ld7_stall_at_rsp", W'(stall), 1);
        checkOutput("ld7_ld_ready", W'(ldReady), 1);
        applyStimulus();
        #1;
        checkOutput("ld7_stall_released", W'(stall), 0);
        checkOutput("ld7_fwd_ra", raOut, 32'h1234);

        // ALU and load response collide: ALU first, load next cycle
        ldIssue = 1'b1; ldIssueRd = 5'd9;
        applyStimulus();
        raUse = 1'b0;
        aluWe = 1'b1; aluRd = 5'd9;
        #1;
        checkOutput("waw_stall_x9", W'(stall), 1);
        aluWe = 1'b1; aluRd = 5'd3; aluData = 32'h33;
        ldValid = 1'b1; ldRd = 5'd9; ldData = 32'h99;
        raSel = 5'd9; raUse = 1'b1;
        #1;
        checkOutput("arb_ld_not_ready", W'(ldReady), 0);
        checkOutput("arb_stall_x9", W'(stall), 1);
        applyStimulus();
        ldValid = 1'b1; ldRd = 5'd9; ldData = 32'h99;
        #1;
        checkOutput("arb_ld_ready", W'(ldReady), 1);
        checkOutput("arb_stall_x9_rsp", W'(stall), 1);
        applyStimulus();
        #1;
        checkOutput("arb_x9_cleared", W'(stall), 0);
        checkOutput("arb_x9_fwd", raOut, 32'h99);
        raUse = 1'b0;

        // Fill the tracker with four loads, then issue a fifth as one retires
        for (int i = 1; i <= 4; i++) begin
            ldIssue = 1'b1; ldIssueRd = RW'(i);
            #1;
            checkOutput("fill_issue_ready", W'(ldIssueReady), 1);
            applyStimulus();
        end
        ldIssue = 1'b1; ldIssueRd = 5'd5;
        #1;
        checkOutput("full_issue_blocked", W'(ldIssueReady), 0);
        ldValid = 1'b1; ldRd = 5'd1; ldData = 32'h11;
        #1;
        checkOutput("full_issue_on_retire", W'(ldIssueReady), 1);
        applyStimulus();
        ldIssueRd = 5'd6;
        #1;
        checkOutput("still_full", W'(ldIssueReady), 0);
        for (int i = 2; i <= 5; i++) begin
            ldValid = 1'b1; ldRd = RW'(i); ldData = W'(32'h10 * i);
            applyStimulus();
        end
        ldIssueRd = 5'd6;
        #1;
        checkOutput("drained_ready", W'(ldIssueReady), 1);

        // Load to x0: no pending bit, no write enable, count returns to zero
        ldIssue = 1'b1; ldIssueRd = 5'd0;
        applyStimulus();
        raSel = 5'd0; raUse = 1'b1; raRf = 32'hF00; ldIssueRd = 5'd0;
        #1;
        checkOutput("x0_no_stall", W'(stall), 0);
        checkOutput("x0_issue_ready", W'(ldIssueReady), 1);
        ldValid = 1'b1; ldRd = 5'd0; ldData = 32'hABCD;
        applyStimulus();
        #1;
        checkOutput("x0_wb_we", W'(wbWe), 0);
        checkOutput("x0_wb_rd", W'(wbRd), 0);
        checkOutput("x0_wb_data", wbData, 32'hABCD);
        checkOutput("x0_no_fwd", raOut, 32'hF00);
        raUse = 1'b0; raRf = '0;
        for (int i = 10; i <= 13; i++) begin
            ldIssue = 1'b1; ldIssueRd = RW'(i);
            #1;
            checkOutput("x0_cnt_zero_issue", W'(ldIssueReady), 1);
            applyStimulus();
        end
        ldIssueRd = 5'd14;
        #1;
        checkOutput("x0_cnt_full", W'(ldIssueReady), 0);

        // Asynchronous reset with loads outstanding and a write in flight
        aluWe = 1'b1; aluRd = 5'd20; aluData = 32'h55;
        applyStimulus();
        checkOutput("pre_rst_wb_we", W'(wbWe), 1);
        #1;
        Rst_ni = 1'b0;
        #1;
        expQ.delete();
        raSel = 5'd10; raUse = 1'b1; ldIssueRd = 5'd10;
        #0;
        checkOutput("async_rst_wb_we", W'(wbWe), 0);
        checkOutput("async_rst_wb_rd", W'(wbRd), 0);
        checkOutput("async_rst_wb_data", wbData, 0);
        checkOutput("async_rst_no_stall", W'(stall), 0);
        checkOutput("async_rst_issue_ready", W'(ldIssueReady), 1);
        #1;
        Rst_ni = 1'b1;

        // Stale response after reset is still written; count stays at zero
        ldValid = 1'b1; ldRd = 5'd10; ldData = 32'h77;
        applyStimulus();
        #1;
        checkOutput("stale_fwd", raOut, 32'h77);
        checkOutput("stale_no_stall", W'(stall), 0);
        raUse = 1'b0;
        for (int i = 21; i <= 24; i++) begin
            ldIssue = 1'b1; ldIssueRd = RW'(i);
            #1;
            checkOutput("stale_cnt_issue", W'(ldIssueReady), 1);
            applyStimulus();
        end
        ldIssueRd = 5'd25;
        #1;
        checkOutput("stale_cnt_full", W'(ldIssueReady), 0);

        applyStimulus();
        applyStimulus();
        checkOutput("queue_drained", W'(expQ.size()), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
